// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson ring run controller.
//   state_t       : controller states (IDLE / RUN / PAUSE)
//   DIR_FWD/REV   : ring direction encoding (0 = shift left, 1 = shift right)
//   johnson_phase : ring position of a Johnson pattern, 0 .. 2*width-1
package johnson_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   // A Johnson pattern fills with ones from bit 0 upward, then drains from
   // bit 0 upward. Bit 0 tells which half of the ring we are in, and the
   // number of ones gives the distance into that half.
   function automatic int johnson_phase(input logic [31:0] q, input int width);
      int ones;
      ones = 0;
      for (int i = 0; i < 32; i++) begin
         if (i < width) begin
            ones = ones + int'(q[i]);
         end
      end
      if (ones == 0) begin
         return 0;
      end else if (q[0]) begin
         return ones;
      end else begin
         return (2 * width) - ones;
      end
   endfunction

endpackage

// File: rtl/johnson_core.sv
// WIDTH-bit Johnson (twisted-ring) register.
//   clk   : clock, posedge
//   rst   : synchronous active-low reset (q -> 0)
//   en    : advance one step this edge
//   dir   : DIR_FWD shifts left, DIR_REV shifts right
//   clr   : synchronous clear to 0, wins over en
//   q/qb  : registered ring state and its complement
//   q_nxt : value q would take on an enabled step (lets the controller see
//           wrap-around and phase one edge ahead)
module johnson_core
   import johnson_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   output logic [WIDTH-1:0] q_nxt
);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] qb_r;
   logic [WIDTH-1:0] step_s;
   logic [WIDTH-1:0] d_s;

   // One twisted-ring step in the requested direction.
   always_comb begin
      step_s = q_r;
      if (dir == DIR_FWD) begin
         step_s = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
      end else begin
         step_s = {~q_r[0], q_r[WIDTH-1:1]};
      end
   end

   // Next register value: clear beats step, otherwise hold.
   always_comb begin
      d_s = q_r;
      if (clr) begin
         d_s = {WIDTH{1'b0}};
      end else if (en) begin
         d_s = step_s;
      end else begin
         d_s = q_r;
      end
   end

   // Ring register; qb is registered from the same next value so it never
   // lags q.
   always_ff @(posedge clk) begin
      if (!rst) begin
         q_r  <= {WIDTH{1'b0}};
         qb_r <= {WIDTH{1'b1}};
      end else begin
         q_r  <= d_s;
         qb_r <= ~d_s;
      end
   end

   assign q     = q_r;
   assign qb    = qb_r;
   assign q_nxt = step_s;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Run controller for a Johnson ring: runs the ring for a programmed number
// of full revolutions and reports position, revolution count and completion.
//   clk, rst          : clock (posedge) and synchronous active-low reset
//   start             : run request, sampled only in IDLE
//   stop              : abort, priority over hold and start
//   hold              : freeze the ring while busy
//   dir, num_cycles   : direction and revolution target, latched at start
//   q, qb             : ring state and complement
//   phase_idx         : ring position 0 .. 2*WIDTH-1
//   cyc_cnt           : completed revolutions in the current/last run
//   busy, done        : run in progress / one-cycle completion pulse
// All outputs come straight from registers.
module johnson_seq_ctrl
   import johnson_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CYC_W = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         hold,
   input  logic                         dir,
   input  logic [CYC_W-1:0]             num_cycles,
   output logic [WIDTH-1:0]             q,
   output logic [WIDTH-1:0]             qb,
   output logic [$clog2(2*WIDTH)-1:0]   phase_idx,
   output logic [CYC_W-1:0]             cyc_cnt,
   output logic                         busy,
   output logic                         done
);

   localparam int PW = $clog2(2 * WIDTH);
   localparam logic [CYC_W-1:0] CNT_ZERO = {CYC_W{1'b0}};
   localparam logic [CYC_W-1:0] CNT_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};
   localparam logic [PW-1:0]    PH_ZERO  = {PW{1'b0}};
   localparam logic [WIDTH-1:0] Q_ZERO   = {WIDTH{1'b0}};

   state_t           state_r,   state_nxt_s;
   logic [CYC_W-1:0] target_r,  target_s;
   logic             dir_r,     dir_s;
   logic [CYC_W-1:0] cyc_cnt_r, cyc_cnt_s;
   logic [PW-1:0]    phase_r,   phase_s;
   logic             busy_r;
   logic             done_r,    done_s;
   logic [CYC_W-1:0] cnt_inc_s;
   logic             core_en_s;
   logic             core_clr_s;
   logic [WIDTH-1:0] q_s;
   logic [WIDTH-1:0] qb_s;
   logic [WIDTH-1:0] q_nxt_s;

   johnson_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk   (clk),
      .rst   (rst),
      .en    (core_en_s),
      .dir   (dir_r),
      .clr   (core_clr_s),
      .q     (q_s),
      .qb    (qb_s),
      .q_nxt (q_nxt_s)
   );

   // Sequencing: next state, ring control and next values of the reported
   // counters. PAUSE with hold released steps on that same edge, so every
   // busy edge with hold=0 and stop=0 is a ring step.
   always_comb begin
      state_nxt_s = state_r;
      target_s    = target_r;
      dir_s       = dir_r;
      cyc_cnt_s   = cyc_cnt_r;
      phase_s     = phase_r;
      done_s      = 1'b0;
      core_en_s   = 1'b0;
      core_clr_s  = 1'b0;
      cnt_inc_s   = cyc_cnt_r + CNT_ONE;
      case (state_r)
         IDLE: begin
            if (start && !stop) begin
               if (num_cycles != CNT_ZERO) begin
                  state_nxt_s = RUN;
                  target_s    = num_cycles;
                  dir_s       = dir;
                  cyc_cnt_s   = CNT_ZERO;
               end else begin
                  // Zero-length run completes immediately.
                  done_s = 1'b1;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN, PAUSE: begin
            if (stop) begin
               state_nxt_s = IDLE;
               core_clr_s  = 1'b1;
               phase_s     = PH_ZERO;
            end else if (hold) begin
               state_nxt_s = PAUSE;
            end else begin
               state_nxt_s = RUN;
               core_en_s   = 1'b1;
               phase_s     = PW'(johnson_phase(32'(q_nxt_s), WIDTH));
               // Returning to all-zero closes a revolution in either direction.
               if (q_nxt_s == Q_ZERO) begin
                  cyc_cnt_s = cnt_inc_s;
                  if (cnt_inc_s == target_r) begin
                     state_nxt_s = IDLE;
                     done_s      = 1'b1;
                  end else begin
                     state_nxt_s = RUN;
                  end
               end else begin
                  state_nxt_s = RUN;
               end
            end
         end
         default: begin
            state_nxt_s = IDLE;
            core_clr_s  = 1'b1;
            phase_s     = PH_ZERO;
         end
      endcase
   end

   // Controller registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= IDLE;
         target_r  <= CNT_ZERO;
         dir_r     <= DIR_FWD;
         cyc_cnt_r <= CNT_ZERO;
         phase_r   <= PH_ZERO;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         target_r  <= target_s;
         dir_r     <= dir_s;
         cyc_cnt_r <= cyc_cnt_s;
         phase_r   <= phase_s;
         busy_r    <= (state_nxt_s != IDLE);
         done_r    <= done_s;
      end
   end

   assign q         = q_s;
   assign qb        = qb_s;
   assign phase_idx = phase_r;
   assign cyc_cnt   = cyc_cnt_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule
